// File: rtl/el2_lsu_clkgate_pkg.sv
// Shared limits, types and helpers for the LSU clock-enable controller.
// Optional gated-cycle statistics are enabled with LSU_CLKGATE_STATS_EN.
package el2_lsu_clkgate_pkg;

    localparam int LSU_MIN_NSTAGE = 2;
    localparam int LSU_MAX_NSTAGE = 8;
    localparam int LSU_MIN_NBUF   = 1;
    localparam int LSU_MAX_NBUF   = 16;
    localparam int LSU_HOLD_W     = 3;
    localparam int LSU_STATS_W    = 32;

    typedef logic [LSU_HOLD_W-1:0] el2_lsu_hold_t;

    // Saturating increment used by the statistics counter.
    function automatic logic [LSU_STATS_W-1:0] lsu_sat_inc(input logic [LSU_STATS_W-1:0] val);
        logic [LSU_STATS_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/el2_lsu_hold_ctr.sv
// One buffer channel: idle-hold countdown plus its bus-qualified clock enable.
// A busy cycle reloads the count from hold_cfg; otherwise it decays to zero.
module el2_lsu_hold_ctr
    import el2_lsu_clkgate_pkg::*;
#(
    parameter int HOLD_W = LSU_HOLD_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              busy,
    input  logic              bus_qual,
    input  logic              bus_clk_en,
    input  logic              clk_override,
    input  logic [HOLD_W-1:0] hold_cfg,
    output logic              clken,
    output logic              hold_active
);

    logic [HOLD_W-1:0] cnt_r;
    logic [HOLD_W-1:0] cnt_nxt_s;
    logic              raw_s;

    // Next count: reload wins over expiry, otherwise saturating decrement.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (busy) begin
            cnt_nxt_s = hold_cfg;
        end else if (cnt_r != {HOLD_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - HOLD_W'(1'b1);
        end else begin
            cnt_nxt_s = {HOLD_W{1'b0}};
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_r <= {HOLD_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Channel enable; override is still masked on bus-qualified channels.
    always_comb begin
        hold_active = (cnt_r != {HOLD_W{1'b0}});
        raw_s       = busy | hold_active | clk_override;
        if (bus_qual) begin
            clken = raw_s & bus_clk_en;
        end else begin
            clken = raw_s;
        end
    end

endmodule

// File: rtl/el2_lsu_clkgate_ctl.sv
// LSU clock-enable controller: stage c1/c2/store enables, per-channel buffer enables,
// free-clock enable and idle flag. LSU_CLKGATE_STATS_EN adds a gated-cycle counter.
module el2_lsu_clkgate_ctl
    import el2_lsu_clkgate_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int NBUF   = 4,
    parameter int HOLD_W = LSU_HOLD_W
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   clk_override,
    input  logic                   dma_dccm_req,
    input  logic [NSTAGE-1:0]      stage_vld,
    input  logic [NSTAGE-1:0]      stage_store,
    input  logic [NBUF-1:0]        buf_busy,
    input  logic [NBUF-1:0]        buf_bus_qual,
    input  logic                   lsu_bus_clk_en,
    input  logic [HOLD_W-1:0]      hold_cfg,
`ifdef LSU_CLKGATE_STATS_EN
    input  logic                   stats_clr,
    output logic [LSU_STATS_W-1:0] gated_cycles,
`endif
    output logic [NSTAGE-1:0]      c1_clken,
    output logic [NSTAGE-1:0]      c2_clken,
    output logic [NSTAGE-1:0]      store_c1_clken,
    output logic [NBUF-1:0]        buf_clken,
    output logic                   free_c2_clken,
    output logic                   lsu_idle
);

    if ((NSTAGE < LSU_MIN_NSTAGE) || (NSTAGE > LSU_MAX_NSTAGE) ||
        (NBUF < LSU_MIN_NBUF) || (NBUF > LSU_MAX_NBUF) || (HOLD_W < 1)) begin : g_bad_cfg
        $error("el2_lsu_clkgate_ctl: illegal NSTAGE/NBUF/HOLD_W");
    end

    logic [NSTAGE-1:0] c1_q_r;
    logic [NSTAGE-1:0] c1_s;
    logic [NSTAGE-1:0] store_src_s;
    logic [NBUF-1:0]   hold_act_s;
    logic              free_c1_s;
    logic              free_q_r;
    logic              idle_r;
    logic              unused_store_top_s;

    // The last stage's store bit has no downstream stage to qualify.
    assign unused_store_top_s = stage_store[NSTAGE-1];

    // Stage enables: stage 0 wakes on entry or DMA, later stages on the packet moving in.
    always_comb begin
        c1_s    = {NSTAGE{1'b0}};
        c1_s[0] = stage_vld[0] | dma_dccm_req | clk_override;
        for (int k = 1; k < NSTAGE; k++) begin
            c1_s[k] = stage_vld[k] | c1_q_r[k-1] | clk_override;
        end
    end

    // Store qualifier of the packet entering each stage.
    assign store_src_s = {stage_store[NSTAGE-2:0], stage_store[0]};

    assign c1_clken       = c1_s;
    assign c2_clken       = c1_s | c1_q_r | {NSTAGE{clk_override}};
    assign store_c1_clken = (c1_s & store_src_s) | {NSTAGE{clk_override}};

    for (genvar j = 0; j < NBUF; j++) begin : g_buf
        el2_lsu_hold_ctr #(
            .HOLD_W       (HOLD_W)
        ) u_hold_ctr (
            .clk          (clk),
            .rst_l        (rst_l),
            .busy         (buf_busy[j]),
            .bus_qual     (buf_bus_qual[j]),
            .bus_clk_en   (lsu_bus_clk_en),
            .clk_override (clk_override),
            .hold_cfg     (hold_cfg),
            .clken        (buf_clken[j]),
            .hold_active  (hold_act_s[j])
        );
    end

    // Any activity anywhere keeps the free clock running.
    always_comb begin
        free_c1_s = (|stage_vld) | (|buf_busy) | (|hold_act_s) | dma_dccm_req | clk_override;
    end

    assign free_c2_clken = free_c1_s | free_q_r;
    assign lsu_idle      = idle_r;

    // Stage history, free-clock stretch and idle flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            c1_q_r   <= {NSTAGE{1'b0}};
            free_q_r <= 1'b0;
            idle_r   <= 1'b1;
        end else begin
            c1_q_r   <= c1_s;
            free_q_r <= free_c1_s;
            idle_r   <= ~free_c1_s;
        end
    end

`ifdef LSU_CLKGATE_STATS_EN
    logic [LSU_STATS_W-1:0] gated_r;

    // Saturating count of cycles with the free clock gated; clear wins.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            gated_r <= {LSU_STATS_W{1'b0}};
        end else if (stats_clr) begin
            gated_r <= {LSU_STATS_W{1'b0}};
        end else if (!free_c2_clken) begin
            gated_r <= lsu_sat_inc(gated_r);
        end else begin
            gated_r <= gated_r;
        end
    end

    assign gated_cycles = gated_r;
`endif

endmodule

// File: tb/tb_el2_lsu_clkgate_ctl.sv
// Self-checking bench for el2_lsu_clkgate_ctl: directed vector table, async reset
// mid-hold, and random stimulus against a behavioural model (stats with LSU_CLKGATE_STATS_EN).
module tb_el2_lsu_clkgate_ctl;
    import el2_lsu_clkgate_pkg::*;

    localparam int NS = 3;
    localparam int NB = 4;
    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          clk_override = 1'b0;
    logic          dma_dccm_req = 1'b0;
    logic [NS-1:0] stage_vld = '0;
    logic [NS-1:0] stage_store = '0;
    logic [NB-1:0] buf_busy = '0;
    logic [NB-1:0] buf_bus_qual = '0;
    logic          lsu_bus_clk_en = 1'b0;
    logic [HW-1:0] hold_cfg = '0;
    logic [NS-1:0] c1_clken, c2_clken, store_c1_clken;
    logic [NB-1:0] buf_clken;
    logic          free_c2_clken, lsu_idle;
`ifdef LSU_CLKGATE_STATS_EN
    logic          stats_clr = 1'b0;
    logic [31:0]   gated_cycles;
    logic [31:0]   m_gated;
`endif

    always #5 clk = ~clk;

    el2_lsu_clkgate_ctl #(.NSTAGE(NS), .NBUF(NB), .HOLD_W(HW)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .clk_override   (clk_override),
        .dma_dccm_req   (dma_dccm_req),
        .stage_vld      (stage_vld),
        .stage_store    (stage_store),
        .buf_busy       (buf_busy),
        .buf_bus_qual   (buf_bus_qual),
        .lsu_bus_clk_en (lsu_bus_clk_en),
        .hold_cfg       (hold_cfg),
`ifdef LSU_CLKGATE_STATS_EN
        .stats_clr      (stats_clr),
        .gated_cycles   (gated_cycles),
`endif
        .c1_clken       (c1_clken),
        .c2_clken       (c2_clken),
        .store_c1_clken (store_c1_clken),
        .buf_clken      (buf_clken),
        .free_c2_clken  (free_c2_clken),
        .lsu_idle       (lsu_idle)
    );

    typedef struct {
        logic [NS-1:0] vld, st;
        logic          dma;
        logic [NB-1:0] busy, qual;
        logic          ben, ovr;
        logic [HW-1:0] cfg;
        logic [NS-1:0] e_c1, e_c2, e_sc;
        logic [NB-1:0] e_buf;
        logic          e_free, e_idle;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    // Behavioural model state: last cycle's stage enables, remaining hold per channel.
    logic [NS-1:0] m_prev_c1;
    int            m_hold[NB];
    logic          m_prev_free, m_idle;
    logic [NS-1:0] m_c1, m_c2, m_sc;
    logic [NB-1:0] m_buf;
    logic          m_free_c1, m_free;

    function automatic vec_t r(logic [2:0] vld, logic [2:0] st, logic dma, logic [3:0] busy,
                               logic [3:0] qual, logic ben, logic ovr, logic [2:0] cfg,
                               logic [2:0] c1, logic [2:0] c2, logic [2:0] sc, logic [3:0] bf,
                               logic fr, logic idl);
        vec_t v;
        v.vld = vld; v.st = st; v.dma = dma; v.busy = busy; v.qual = qual;
        v.ben = ben; v.ovr = ovr; v.cfg = cfg;
        v.e_c1 = c1; v.e_c2 = c2; v.e_sc = sc; v.e_buf = bf; v.e_free = fr; v.e_idle = idl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_c1   = '0;
        m_prev_free = 1'b0;
        m_idle      = 1'b1;
        for (int j = 0; j < NB; j++) m_hold[j] = 0;
`ifdef LSU_CLKGATE_STATS_EN
        m_gated = 32'd0;
`endif
    endtask

    task automatic model_eval();
        logic feed, act;
        int   si;
        m_free_c1 = dma_dccm_req | clk_override;
        for (int k = 0; k < NS; k++) begin
            if (k == 0) begin
                feed = dma_dccm_req;
                si   = 0;
            end else begin
                feed = m_prev_c1[k-1];
                si   = k - 1;
            end
            m_c1[k] = stage_vld[k] | feed | clk_override;
            m_c2[k] = m_c1[k] | m_prev_c1[k] | clk_override;
            m_sc[k] = (m_c1[k] & stage_store[si]) | clk_override;
            m_free_c1 = m_free_c1 | stage_vld[k];
        end
        for (int j = 0; j < NB; j++) begin
            act      = buf_busy[j] | (m_hold[j] > 0) | clk_override;
            m_buf[j] = buf_bus_qual[j] ? (act & lsu_bus_clk_en) : act;
            m_free_c1 = m_free_c1 | buf_busy[j] | (m_hold[j] > 0);
        end
        m_free = m_free_c1 | m_prev_free;
    endtask

    task automatic model_step();
`ifdef LSU_CLKGATE_STATS_EN
        if (stats_clr) m_gated = 32'd0;
        else if (!m_free && m_gated != 32'hFFFF_FFFF) m_gated = m_gated + 32'd1;
`endif
        m_prev_c1   = m_c1;
        m_prev_free = m_free_c1;
        m_idle      = ~m_free_c1;
        for (int j = 0; j < NB; j++) begin
            if (buf_busy[j]) m_hold[j] = int'(hold_cfg);
            else if (m_hold[j] > 0) m_hold[j] = m_hold[j] - 1;
        end
    endtask

    task automatic drive(input vec_t v);
        stage_vld = v.vld; stage_store = v.st; dma_dccm_req = v.dma;
        buf_busy = v.busy; buf_bus_qual = v.qual; lsu_bus_clk_en = v.ben;
        clk_override = v.ovr; hold_cfg = v.cfg;
    endtask

    // One cycle: drive at negedge, compare just after, advance the model at posedge.
    task automatic cycle(input vec_t v, input logic use_tbl);
        @(negedge clk);
        drive(v);
        #1;
        model_eval();
        chk("c1", 32'(c1_clken), 32'(m_c1));
        chk("c2", 32'(c2_clken), 32'(m_c2));
        chk("store_c1", 32'(store_c1_clken), 32'(m_sc));
        chk("buf", 32'(buf_clken), 32'(m_buf));
        chk("free_c2", 32'(free_c2_clken), 32'(m_free));
        chk("idle", 32'(lsu_idle), 32'(m_idle));
`ifdef LSU_CLKGATE_STATS_EN
        chk("gated", gated_cycles, m_gated);
`endif
        if (use_tbl) begin
            chk("tbl_c1", 32'(c1_clken), 32'(v.e_c1));
            chk("tbl_c2", 32'(c2_clken), 32'(v.e_c2));
            chk("tbl_store", 32'(store_c1_clken), 32'(v.e_sc));
            chk("tbl_buf", 32'(buf_clken), 32'(v.e_buf));
            chk("tbl_free", 32'(free_c2_clken), 32'(v.e_free));
            chk("tbl_idle", 32'(lsu_idle), 32'(v.e_idle));
        end
        @(posedge clk);
        if (!rst_l) model_reset();
        else model_step();
    endtask

    initial begin
        vec_t q, v;
        q = r(3'b000, 3'b000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0,
              3'b000, 3'b000, 3'b000, 4'b0000, 1'b0, 1'b1);
        model_reset();

        // Reset state with everything quiet.
        cycle(q, 1'b1);
        cycle(q, 1'b1);
        @(posedge clk);
        #2 rst_l = 1'b1;

        // Pipeline walk, store/load qualification, hold, bus qualification, override, DMA, reload.
        for (int i = 0; i < 5; i++) tbl.push_back(q);
        tbl.push_back(r(3'b001,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b001,3'b001,3'b000,4'b0000,1'b1,1'b1));
        tbl.push_back(r(3'b010,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b010,3'b011,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b100,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b100,3'b110,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b100,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(q);
        tbl.push_back(r(3'b010,3'b010,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b010,3'b010,3'b000,4'b0000,1'b1,1'b1));
        tbl.push_back(r(3'b000,3'b010,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b100,3'b110,3'b100,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b010,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b100,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(r(3'b010,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b010,3'b010,3'b000,4'b0000,1'b1,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b100,3'b110,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b100,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(q);
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0010,4'b0000,1'b0,1'b0,3'd3, 3'b000,3'b000,3'b000,4'b0010,1'b1,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0010,4'b0000,1'b0,1'b0,3'd3, 3'b000,3'b000,3'b000,4'b0010,1'b1,1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd3, 3'b000,3'b000,3'b000,4'b0010,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd3, 3'b000,3'b000,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd3, 3'b000,3'b000,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0010,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b000,3'b000,4'b0010,1'b1,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b000,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(q);
        for (int i = 0; i < 4; i++) begin
            logic b;
            b = (i % 2 == 0);
            tbl.push_back(r(3'b000,3'b000,1'b0,4'b0100,4'b0100,b,1'b0,3'd0, 3'b000,3'b000,3'b000,
                            b ? 4'b0100 : 4'b0000, 1'b1, (i == 0)));
        end
        for (int i = 0; i < 4; i++) begin
            logic b;
            b = (i % 2 == 0);
            tbl.push_back(r(3'b000,3'b000,1'b0,4'b0100,4'b0100,b,1'b1,3'd0, 3'b111,3'b111,3'b111,
                            b ? 4'b1111 : 4'b1011, 1'b1, 1'b0));
        end
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b110,3'b111,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b100,3'b110,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b100,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(q);
        tbl.push_back(r(3'b000,3'b000,1'b1,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b001,3'b001,3'b000,4'b0000,1'b1,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b010,3'b011,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b100,3'b110,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd0, 3'b000,3'b100,3'b000,4'b0000,1'b0,1'b1));
        tbl.push_back(q);
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0001,4'b0000,1'b0,1'b0,3'd5, 3'b000,3'b000,3'b000,4'b0001,1'b1,1'b1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd5, 3'b000,3'b000,3'b000,4'b0001,1'b1,1'b0));
        // Busy returns as the count reaches 1: reload, enable never drops; cfg change is ignored.
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0001,4'b0000,1'b0,1'b0,3'd5, 3'b000,3'b000,3'b000,4'b0001,1'b1,1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd7, 3'b000,3'b000,3'b000,4'b0001,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd7, 3'b000,3'b000,3'b000,4'b0000,1'b1,1'b0));
        tbl.push_back(r(3'b000,3'b000,1'b0,4'b0000,4'b0000,1'b0,1'b0,3'd7, 3'b000,3'b000,3'b000,4'b0000,1'b0,1'b1));

        foreach (tbl[i]) cycle(tbl[i], 1'b1);

        // Asynchronous reset in the middle of a hold countdown.
        v = q;
        v.busy = 4'b1000;
        v.cfg  = 3'd7;
        cycle(v, 1'b0);
        v.busy = 4'b0000;
        cycle(v, 1'b0);
        cycle(v, 1'b0);
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        chk("rst_buf", 32'(buf_clken), 32'd0);
        chk("rst_idle", 32'(lsu_idle), 32'd1);
        chk("rst_free", 32'(free_c2_clken), 32'd0);
        @(posedge clk);
        #2 rst_l = 1'b1;
        cycle(v, 1'b0);
        chk("post_rst_buf", 32'(buf_clken), 32'd0);

`ifdef LSU_CLKGATE_STATS_EN
        // Clear, then ten fully gated cycles.
        @(negedge clk) stats_clr = 1'b1;
        cycle(q, 1'b0);
        stats_clr = 1'b0;
        for (int i = 0; i < 10; i++) cycle(q, 1'b0);
        #1 chk("gated_10", gated_cycles, 32'd10);
        @(negedge clk) stats_clr = 1'b1;
        cycle(q, 1'b0);
        stats_clr = 1'b0;
        #1 chk("gated_clr", gated_cycles, 32'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            v.vld  = 3'($urandom);
            v.st   = 3'($urandom);
            v.dma  = ($urandom_range(0, 7) == 0);
            v.busy = 4'($urandom & $urandom & $urandom);
            v.qual = 4'($urandom);
            v.ben  = 1'($urandom);
            v.ovr  = ($urandom_range(0, 15) == 0);
            v.cfg  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) v.vld = 3'b000;
            cycle(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
